bu_pipe_lanes: RTL and testbench
================================

// Module: bu_pipe_lanes
// PURPOSE
//  Pipelined, multi-lane NTT/INTT butterfly for Dilithium (q=8380417), with a valid/ready stream interface.
//  Each lane runs a Cooley-Tukey (CT, forward) or Gentleman-Sande (GS, inverse) butterfly with Montgomery multiply.
//  Sits between the coefficient-RAM read port and the write-back port of the NTT controller.
//  Sustains one beat (LANES butterflies) per cycle when out_ready is held high.
// PARAMETERS
//  LANES  2         butterflies per beat, >=1
//  Q      8380417   modulus
//  QINV   58728449  q^-1 mod 2^32
//  TAG_W  8         width of the sideband tag carried alongside each beat
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          input beat valid
//  in_ready   out  1          input beat accepted when in_valid&&in_ready
//  in_mode    in   1          0=GS (inverse), 1=CT (forward); per beat
//  in_a       in   32*LANES   signed coefficient a per lane, lane i = [32i+:32]
//  in_b       in   32*LANES   signed coefficient b per lane
//  in_w       in   32*LANES   signed twiddle per lane, Montgomery form
//  in_tag     in   TAG_W      sideband, returned unchanged with the beat
//  out_valid  out  1          result beat valid
//  out_ready  in   1          downstream accept
//  out_r1     out  32*LANES   result r1 per lane
//  out_r2     out  32*LANES   result r2 per lane
//  out_tag    out  TAG_W      tag of the result beat
//  out_busy   out  1          any pipeline stage holds a valid beat
// BEHAVIOUR
//  Arithmetic (two's-complement, per lane):
//   mont(x): x is 64-bit signed; t = (x[31:0]*QINV)[31:0] as signed; result = (x - t*Q) >>> 32. Result lies in (-Q,Q).
//   red(x): t = (x + 2^22) >>> 23; result = x - t*Q.
//   CT: m = mont(b*w); r1 = a + m; r2 = a - m.
//   GS: r1 = red(a + b); r2 = mont((a - b)*w).
//   All adds and subtracts are 32-bit signed. Inputs are required to satisfy |a|,|b| < 2^30.
//  Pipeline (3 stages, every stage registered):
//   S0: register a, b, w, mode, tag. GS computes d = a - b.
//   S1: 64-bit product p = (CT ? b : d) * w. GS also computes red(a + b).
//   S2: mont(p), then the final add/sub. The output registers drive out_*.
//   Latency is 3 cycles from acceptance to out_valid with no stall.
//  Handshake: adv = !out_valid || out_ready.
//   in_ready = adv, and every stage shifts only when adv is high. There are no bubbles-collapse requirements.
//   out_* hold stable while out_valid && !out_ready.
//   Beats exit in acceptance order. Tag and mode stay aligned with their data.
//  Reset: all stage valid bits = 0, out_valid = 0, out_r1 = out_r2 = 0, out_tag = 0, out_busy = 0, in_ready = 1.
//   Reset asserted mid-stream drops every in-flight beat, with no partial output.
//  Simultaneous events: a beat accepted in the same cycle an output is taken is legal, giving full throughput.
//  Boundaries:
//   GS a = b gives r2 = 0.
//   w = 0 gives CT r1 = r2 = a.
//   Sums reaching ±2Q are handled by red(); there is no saturation.
// CONFIGURATION
//  BU_CANON_EN defined:
//   Adds a stage S3 that maps each r1/r2 into [0,Q): add Q if the value is negative, subtract Q if it is >= Q, applied once.
//   Latency becomes 4 cycles.
//  BU_CANON_EN undefined:
//   Outputs are left centred as computed above, and latency is 3 cycles.
// STRUCTURE
//  Package bu_pkg:
//   localparams Q, QINV, MONT_R = 4193792 (2^32 mod q), and the BU_CT/BU_GS mode enum (typedef bu_mode_e).
//   coeff_t = logic signed [31:0].
//   Functions mont_red() and red32().
//  Sub-module bu_lane:
//   One lane of S0..S2(+S3) datapath with no handshake logic.
//   The top instantiates LANES copies with a generate loop and owns the valid/adv chain, tag pipe and out_busy.
// TESTING
//  1 CT a=5, b=7, w=0 -> r1=5, r2=5 after 3 cycles; tag 0x11 returned unchanged.
//  2 CT a=100, b=7, w=MONT_R -> r1≡107, r2≡93 mod Q; with BU_CANON_EN exactly 107 and 93.
//  3 GS a=Q-1, b=Q-1, w=MONT_R -> r1=-2 (8380415 with BU_CANON_EN), r2=0.
//  4 Stream 16 beats, tags 0..15, random out_ready -> all tags in order, no loss or duplication, out_* stable while stalled.
//  5 out_ready held high, in_valid held high -> one beat out per cycle after the 3-cycle fill; in_ready never drops.
//  6 rst for 1 cycle with 3 beats in flight -> out_valid=0 on the next cycle, no stale beat emitted, in_ready=1.

Source files
------------

// File: rtl/bu_pkg.sv
// Package: bu_pkg
// Shared types, constants and modular-reduction helpers for the Dilithium
// NTT/INTT butterfly pipeline (q = 8380417).
package bu_pkg;

   typedef logic signed [31:0] coeff_t;
   typedef logic signed [63:0] prod_t;

   localparam coeff_t      Q      = 32'sd8380417;
   localparam logic [31:0] QINV   = 32'd58728449;   // q^-1 mod 2^32
   localparam coeff_t      MONT_R = 32'sd4193792;    // 2^32 mod q

   typedef enum logic {
      BU_GS = 1'b0,   // Gentleman-Sande, inverse transform
      BU_CT = 1'b1    // Cooley-Tukey, forward transform
   } bu_mode_e;

   // Signed Montgomery reduction: returns x * 2^-32 mod q, centred in (-q, q).
   function automatic coeff_t mont_red(input prod_t x, input coeff_t q, input logic [31:0] qinv);
      logic [31:0] t_u;
      prod_t       t_s;
      prod_t       q_s;
      prod_t       diff;
      t_u  = x[31:0] * qinv;
      t_s  = {{32{t_u[31]}}, t_u};
      q_s  = {{32{q[31]}}, q};
      diff = x - t_s * q_s;
      return diff[63:32];
   endfunction

   // Barrett-style reduction of a 32-bit sum into roughly (-q/2, q/2].
   function automatic coeff_t red32(input coeff_t x, input coeff_t q);
      coeff_t t;
      t = (x + 32'sd4194304) >>> 23;
      return x - t * q;
   endfunction

   // Single conditional correction of a centred value into [0, q).
   function automatic coeff_t canon32(input coeff_t x, input coeff_t q);
      if (x < 0)
         return x + q;
      else if (x >= q)
         return x - q;
      else
         return x;
   endfunction

endpackage

// File: rtl/bu_lane.sv
// Module: bu_lane
// One butterfly lane: S0 operand capture, S1 product and GS sum reduction,
// S2 Montgomery reduction with final add/sub. With BU_CANON_EN defined an
// extra S3 maps both results into [0, q). No handshake logic lives here; the
// parent drives the stage enable and the output-register load.
module bu_lane
   import bu_pkg::*;
#(
   parameter coeff_t      Q_MOD    = Q,
   parameter logic [31:0] QINV_MOD = QINV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic        out_ld_i,
   input  logic        mode_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] w_i,
   output logic [31:0] r1_o,
   output logic [31:0] r2_o
);

   bu_mode_e mode0_q, mode1_q;
   coeff_t   a0_q, b0_q, w0_q;
   coeff_t   a1_q, red1_q, red1_d;
   prod_t    p1_q, p1_d;
   coeff_t   m2;
   coeff_t   r1_2_d, r2_2_d;
   coeff_t   r1_q, r2_q;

   // S0: capture the incoming operands and mode.
   // NOTE: operand registers carry no reset; the parent's valid chain decides
   // which contents are ever observed, so only the output registers are reset.
   always_ff @(posedge clk) begin
      if (en_i) begin
         // NOTE: non-blocking assignments so each stage samples the pre-edge value of the one before.
         mode0_q <= bu_mode_e'(mode_i);
         a0_q    <= a_i;
         b0_q    <= b_i;
         w0_q    <= w_i;
      end
   end

   // S1 combinational: select the multiplicand (b for CT, a-b for GS) and reduce a+b for GS.
   always_comb begin
      // NOTE: every variable is assigned on every path, so no latch is inferred.
      coeff_t op0;
      op0    = (mode0_q == BU_CT) ? b0_q : (a0_q - b0_q);
      p1_d   = prod_t'(op0) * prod_t'(w0_q);
      red1_d = red32(a0_q + b0_q, Q_MOD);
   end

   // S1: register the 64-bit product, the reduced GS sum and the pass-through a.
   always_ff @(posedge clk) begin
      if (en_i) begin
         mode1_q <= mode0_q;
         a1_q    <= a0_q;
         p1_q    <= p1_d;
         red1_q  <= red1_d;
      end
   end

   // S2 combinational: Montgomery-reduce the product and form r1/r2 for the beat's mode.
   always_comb begin
      m2 = mont_red(p1_q, Q_MOD, QINV_MOD);
      if (mode1_q == BU_CT) begin
         r1_2_d = a1_q + m2;
         r2_2_d = a1_q - m2;
      end else begin
         r1_2_d = red1_q;
         r2_2_d = m2;
      end
   end

`ifdef BU_CANON_EN
   coeff_t r1_2_q, r2_2_q;

   // S2: register the centred results ahead of the canonicalising stage.
   always_ff @(posedge clk) begin
      if (en_i) begin
         r1_2_q <= r1_2_d;
         r2_2_q <= r2_2_d;
      end
   end

   // S3: output registers hold the results mapped into [0, q).
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_q <= '0;
         r2_q <= '0;
      end else if (out_ld_i) begin
         r1_q <= canon32(r1_2_q, Q_MOD);
         r2_q <= canon32(r2_2_q, Q_MOD);
      end
   end
`else
   // S2: output registers hold the centred results.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_q <= '0;
         r2_q <= '0;
      end else if (out_ld_i) begin
         r1_q <= r1_2_d;
         r2_q <= r2_2_d;
      end
   end
`endif

   assign r1_o = r1_q;
   assign r2_o = r2_q;

endmodule

// File: rtl/bu_pipe_lanes.sv
// Module: bu_pipe_lanes
// Multi-lane pipelined CT/GS butterfly with a valid/ready stream interface.
// Owns the stage valid chain, the tag pipe and the global advance signal;
// the arithmetic lives in LANES copies of bu_lane.
// Optional feature: define BU_CANON_EN to add a canonicalising stage
// (outputs in [0, q), latency 4 instead of 3).
module bu_pipe_lanes
   import bu_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter coeff_t      Q     = bu_pkg::Q,
   parameter logic [31:0] QINV  = bu_pkg::QINV,
   parameter int unsigned TAG_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [32*LANES-1:0]   in_a,
   input  logic [32*LANES-1:0]   in_b,
   input  logic [32*LANES-1:0]   in_w,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [32*LANES-1:0]   out_r1,
   output logic [32*LANES-1:0]   out_r2,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  out_busy
);

`ifdef BU_CANON_EN
   localparam int unsigned NSTG = 4;
`else
   localparam int unsigned NSTG = 3;
`endif

   logic             adv;
   logic             out_ld;
   logic [NSTG-1:0]  vld_q, vld_d;
   logic [TAG_W-1:0] tag_q [NSTG-1];
   logic [TAG_W-1:0] out_tag_q;

   // Whole pipeline moves together whenever the output register is free or being drained.
   always_comb begin
      adv    = !vld_q[NSTG-1] || out_ready;
      vld_d  = {vld_q[NSTG-2:0], in_valid};
      out_ld = adv && vld_q[NSTG-2];
   end

   // Valid chain: one bit per stage, the last one is out_valid.
   always_ff @(posedge clk) begin
      if (rst)
         vld_q <= '0;
      else if (adv)
         vld_q <= vld_d;
   end

   // Tag pipe for the internal stages, shifting in lock-step with the lanes.
   always_ff @(posedge clk) begin
      if (adv) begin
         tag_q[0] <= in_tag;
         for (int i = 1; i < int'(NSTG) - 1; i++)
            tag_q[i] <= tag_q[i-1];
      end
   end

   // Output tag register, loaded only with a valid beat so it stays stable under stall.
   always_ff @(posedge clk) begin
      if (rst)
         out_tag_q <= '0;
      else if (out_ld)
         out_tag_q <= tag_q[NSTG-2];
   end

   for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
      bu_lane #(
         .Q_MOD    (Q),
         .QINV_MOD (QINV)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .en_i     (adv),
         .out_ld_i (out_ld),
         .mode_i   (in_mode),
         .a_i      (in_a[32*g +: 32]),
         .b_i      (in_b[32*g +: 32]),
         .w_i      (in_w[32*g +: 32]),
         .r1_o     (out_r1[32*g +: 32]),
         .r2_o     (out_r2[32*g +: 32])
      );
   end

   assign in_ready  = adv;
   assign out_valid = vld_q[NSTG-1];
   assign out_tag   = out_tag_q;
   assign out_busy  = |vld_q;

endmodule

// File: tb/tb_bu_pipe_lanes.sv
// Testbench: tb_bu_pipe_lanes
// Scoreboard bench for bu_pipe_lanes: the driver pushes the hand-computed
// result of each accepted beat, an independent monitor pops and compares on
// every output handshake and checks that outputs hold while stalled.
// Expected values follow BU_CANON_EN when it is defined.
`timescale 1ns/1ps
module tb_bu_pipe_lanes;
   import bu_pkg::*;

   localparam int LANES = 2;
   localparam int TAG_W = 8;
`ifdef BU_CANON_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic                in_mode;
   logic [32*LANES-1:0] in_a, in_b, in_w;
   logic [TAG_W-1:0]    in_tag;
   logic                out_valid;
   logic                out_ready;
   logic [32*LANES-1:0] out_r1, out_r2;
   logic [TAG_W-1:0]    out_tag;
   logic                out_busy;

   bu_pipe_lanes #(.LANES(LANES), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_w      (in_w),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r1    (out_r1),
      .out_r2    (out_r2),
      .out_tag   (out_tag),
      .out_busy  (out_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_out    = 0;
   bit rand_rdy = 0;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [63:0]      r1;
      logic [63:0]      r2;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Expected output word for a centred hand-computed result.
   function automatic logic [31:0] cexp(input int v);
`ifdef BU_CANON_EN
      if (v < 0) return 32'(v + int'(Q));
      if (v >= int'(Q)) return 32'(v - int'(Q));
`endif
      return 32'(v);
   endfunction

   // Present one beat (called at posedge+1) and wait for it to be accepted.
   task automatic send(input logic mode, input logic [TAG_W-1:0] tag,
                       input int a0, input int b0, input int w0,
                       input int a1, input int b1, input int w1,
                       input int e1_0, input int e2_0, input int e1_1, input int e2_1,
                       output int stalls);
      exp_t e;
      bit   done;
      in_valid = 1'b1;
      in_mode  = mode;
      in_tag   = tag;
      in_a     = {32'(a1), 32'(a0)};
      in_b     = {32'(b1), 32'(b0)};
      in_w     = {32'(w1), 32'(w0)};
      e.tag    = tag;
      e.r1     = {cexp(e1_1), cexp(e1_0)};
      e.r2     = {cexp(e2_1), cexp(e2_0)};
      stalls   = 0;
      done     = 1'b0;
      while (!done && stalls < 100) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            done = 1'b1;
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check("send_timeout", 64'd0, 64'd1);
   endtask

   // Stream beat k: even k is CT with w=0 (r1=r2=a), odd k is GS with a=b (r1=2a, r2=0).
   task automatic stream_beat(input int k, input logic [TAG_W-1:0] tag, output int stalls);
      if (k % 2 == 0)
         send(BU_CT, tag, 3*k+1, k, 0, -(k+2), 5, 0,
              3*k+1, 3*k+1, -(k+2), -(k+2), stalls);
      else
         send(BU_GS, tag, 5*k, 5*k, int'(MONT_R), -k, -k, int'(MONT_R),
              10*k, 0, -2*k, 0, stalls);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      in_valid = 1'b0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, 64'(sb.size()), 64'd0);
   endtask

   // Random downstream back-pressure, active only while rand_rdy is set.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   // Monitor: compare every taken beat against the scoreboard and check stall stability.
   initial begin
      exp_t             e;
      bit               hold;
      logic [63:0]      h_r1, h_r2;
      logic [TAG_W-1:0] h_tag;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (hold && out_valid) begin
            check("stall_r1",  out_r1, h_r1);
            check("stall_r2",  out_r2, h_r2);
            check("stall_tag", 64'(out_tag), 64'(h_tag));
         end
         hold = 1'b0;
         if (out_valid && !out_ready) begin
            hold  = 1'b1;
            h_r1  = out_r1;
            h_r2  = out_r2;
            h_tag = out_tag;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", 64'(out_tag), 64'hFFFF);
            end else begin
               e = sb.pop_front();
               check($sformatf("beat%0h_tag", e.tag), 64'(out_tag), 64'(e.tag));
               check($sformatf("beat%0h_r1", e.tag), out_r1, e.r1);
               check($sformatf("beat%0h_r2", e.tag), out_r2, e.r2);
               n_out++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int st;
      int n0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_w      = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      // Reset state
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_busy",  64'(out_busy),  64'd0);
      check("rst_out_r1",    out_r1,         64'd0);
      check("rst_out_r2",    out_r2,         64'd0);
      check("rst_out_tag",   64'(out_tag),   64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // 1: CT with w=0 returns a on both outputs; latency and tag pass-through.
      send(BU_CT, 8'h11, 5, 7, 0, -50, 123, 0, 5, 5, -50, -50, st);
      in_valid = 1'b0;
      @(negedge clk);
      check("t1_busy_in_flight", 64'(out_busy), 64'd1);
      repeat (LAT-2) @(negedge clk);
      check("t1_latency_not_early", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("t1_latency_on_time", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      idle(3);

      // 2: CT with w = MONT_R: m = b exactly.
      send(BU_CT, 8'h22, 100, 7, int'(MONT_R), 0, -7, int'(MONT_R), 107, 93, -7, 7, st);
      // 3: GS near 2Q and a=b, then a general GS beat.
      send(BU_GS, 8'h33, int'(Q)-1, int'(Q)-1, int'(MONT_R), -(int'(Q)-1), -(int'(Q)-1), 12345,
           -2, 0, 2, 0, st);
      send(BU_GS, 8'h34, 10, 3, int'(MONT_R), 3, 10, int'(MONT_R), 13, 7, 13, -7, st);
      drain("t23_drain");

      // 4: 16-beat stream under random back-pressure.
      n0 = n_out;
      rand_rdy = 1'b1;
      for (int k = 0; k < 16; k++) stream_beat(k, 8'(k), st);
      drain("t4_drain");
      rand_rdy  = 1'b0;
      out_ready = 1'b1;
      check("t4_beat_count", 64'(n_out - n0), 64'd16);
      idle(2);

      // 5: full throughput with out_ready held high.
      n0 = n_out;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               stream_beat(k, 8'(8'h40 + k), st);
               check($sformatf("t5_in_ready_stall%0d", k), 64'(st), 64'd0);
            end
            in_valid = 1'b0;
         end
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            check("t5_first_out", 64'(out_valid), 64'd1);
            for (int i = 1; i < 8; i++) begin
               @(negedge clk);
               check($sformatf("t5_back_to_back%0d", i), 64'(out_valid), 64'd1);
            end
         end
      join
      @(posedge clk);
      #1;
      drain("t5_drain");
      check("t5_beat_count", 64'(n_out - n0), 64'd8);

      // 6: reset with three beats in flight.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) stream_beat(k, 8'(8'h60 + k), st);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check("t6_out_valid", 64'(out_valid), 64'd0);
      check("t6_in_ready",  64'(in_ready),  64'd1);
      check("t6_out_busy",  64'(out_busy),  64'd0);
      check("t6_out_tag",   64'(out_tag),   64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      n0 = n_out;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("t6_no_stale%0d", i), 64'(out_valid), 64'd0);
      end
      check("t6_no_output", 64'(n_out - n0), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
